// File: rtl/tribus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus: one driver enabled at a time,
// with a forced all-off turnaround gap between owners and the keeper enabled while idle.
module tribus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8,
    parameter int TURN_CYC = 1,
    localparam int OW      = $clog2(N_REQ),
    localparam int HW      = $clog2(HOLD_MAX + 1),
    localparam int TW      = $clog2(TURN_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] drv_en,
    output logic [OW-1:0]    owner,
    output logic             bus_pchg
);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   turn_cnt;

    logic [OW-1:0]   win_idx;
    logic            win_any;
    logic [N_REQ-1:0] others;
    logic            exit_own;
    logic            arb_now;

    // Rotating priority: scan from highest offset down so the lowest offset from ptr wins.
    always_comb begin
        int idx;
        win_idx = '0;
        win_any = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) win_idx = OW'(idx);
        end
    end

    always_comb begin
        others        = req;
        others[owner] = 1'b0;
        exit_own = done[owner] || !req[owner] ||
                   ((hold_cnt == HW'(HOLD_MAX)) && (|others));
        arb_now  = (state == IDLE) || ((state == TURN) && (turn_cnt == TW'(TURN_CYC)));
    end

    // Outputs are registered; an asynchronous reset drops every driver without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            gnt      <= '0;
            owner    <= '0;
            bus_pchg <= 1'b1;
        end else if (arb_now) begin
            if (win_any) begin
                state    <= OWN;
                gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                owner    <= win_idx;
                hold_cnt <= HW'(1);
                bus_pchg <= 1'b0;
            end else begin
                state    <= IDLE;
                gnt      <= '0;
                bus_pchg <= 1'b1;
            end
        end else if (state == OWN) begin
            if (exit_own) begin
                state    <= TURN;
                gnt      <= '0;
                bus_pchg <= 1'b1;
                ptr      <= (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                turn_cnt <= TW'(1);
            end else if (hold_cnt != HW'(HOLD_MAX)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end else begin
            turn_cnt <= turn_cnt + 1'b1;
        end
    end

    assign drv_en = gnt;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Self-checking bench for tribus_arbiter: vector table, hand sequences and a random invariant run.
module tb_tribus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [3:0] drv_en;
    logic [1:0] owner;
    logic       bus_pchg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] owner;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] owner;
    } exp_t;

    exp_t sb[$];

    tribus_arbiter #(.N_REQ(4), .HOLD_MAX(8), .TURN_CYC(1)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .drv_en(drv_en), .owner(owner), .bus_pchg(bus_pchg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic step(input logic [3:0] r, input logic [3:0] d,
                        input logic [3:0] eg, input logic [1:0] eo, input string tag);
        exp_t e;
        req  = r;
        done = d;
        sb.push_back('{eg, eo});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
        chk({tag, ".drv_en"}, 32'(drv_en), 32'(e.gnt));
        chk({tag, ".owner"}, 32'(owner), 32'(e.owner));
        chk({tag, ".pchg"}, 32'(bus_pchg), 32'(e.gnt == 4'b0));
        $display("%s req=%b done=%b gnt=%b owner=%0d pchg=%b", tag, r, d, gnt, owner, bus_pchg);
    endtask

    initial begin
        vec_t tbl[$];
        int o;
        logic [3:0] last_nz;
        int zeros;
        int wait_cnt[4];
        logic [3:0] r_drv;
        logic rst_drv;

        tbl = '{
            // single requester 2, released by done during its 5th cycle
            '{4'b0100, 4'b0000, 4'b0100, 2'd2},
            '{4'b0100, 4'b0000, 4'b0100, 2'd2},
            '{4'b0100, 4'b0000, 4'b0100, 2'd2},
            '{4'b0100, 4'b0000, 4'b0100, 2'd2},
            '{4'b0100, 4'b0000, 4'b0100, 2'd2},
            '{4'b0000, 4'b0100, 4'b0000, 2'd2},
            '{4'b0000, 4'b0000, 4'b0000, 2'd2},
            '{4'b0000, 4'b0000, 4'b0000, 2'd2},
            // ptr=3: owner 0, foreign done ignored, req drop hands over to 3
            '{4'b0001, 4'b0000, 4'b0001, 2'd0},
            '{4'b1001, 4'b1000, 4'b0001, 2'd0},
            '{4'b1001, 4'b0000, 4'b0001, 2'd0},
            '{4'b1000, 4'b0000, 4'b0000, 2'd0},
            '{4'b1000, 4'b0000, 4'b1000, 2'd3},
            '{4'b1000, 4'b1000, 4'b0000, 2'd3},
            '{4'b1000, 4'b0000, 4'b1000, 2'd3},
            '{4'b0100, 4'b1000, 4'b0000, 2'd3},
            '{4'b0100, 4'b0000, 4'b0100, 2'd2},
            '{4'b0000, 4'b0000, 4'b0000, 2'd2},
            '{4'b0000, 4'b0000, 4'b0000, 2'd2}
        };

        rst  = 1'b1;
        req  = 4'b0;
        done = 4'b0;
        #12;
        chk("reset.gnt", 32'(gnt), 32'h0);
        chk("reset.drv_en", 32'(drv_en), 32'h0);
        chk("reset.owner", 32'(owner), 32'h0);
        chk("reset.pchg", 32'(bus_pchg), 32'h1);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].req, tbl[i].done, tbl[i].gnt, tbl[i].owner, $sformatf("vec%0d", i));

        // sole requester 1 (ptr=3) held 30 cycles: never preempted
        for (int i = 0; i < 30; i++)
            step(4'b0010, 4'b0000, 4'b0010, 2'd1, $sformatf("sole%0d", i));
        // hold already saturated, so a second requester preempts at the next edge
        step(4'b0011, 4'b0000, 4'b0000, 2'd1, "preempt");
        step(4'b0011, 4'b0000, 4'b0001, 2'd0, "after_preempt");
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, "rel0");
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, "idle0");

        // all requesting from ptr=1: 8 owned cycles then one dead cycle per owner
        o = 1;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++)
                step(4'b1111, 4'b0000, 4'b0001 << o, 2'(o), $sformatf("rr%0d_%0d", k, c));
            step(4'b1111, 4'b0000, 4'b0000, 2'(o), $sformatf("rr%0d_gap", k));
            o = (o + 1) % 4;
        end
        step(4'b0000, 4'b0000, 4'b0000, 2'd1, "rr_end");

        // asynchronous reset mid-ownership (ptr=2 here)
        step(4'b0010, 4'b0000, 4'b0010, 2'd1, "pre_rst");
        #2 rst = 1'b1;
        #1;
        chk("async_rst.gnt", 32'(gnt), 32'h0);
        chk("async_rst.drv_en", 32'(drv_en), 32'h0);
        chk("async_rst.pchg", 32'(bus_pchg), 32'h1);
        #2 rst = 1'b0;
        step(4'b1111, 4'b0000, 4'b0001, 2'd0, "post_rst_ptr0");
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, "post_rst_rel");
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, "post_rst_idle");

        // random run with invariant checks
        last_nz = 4'b0;
        zeros   = 1;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        r_drv = 4'b0;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(7) == 0) r_drv[i] = ~r_drv[i];
            rst_drv = ($urandom_range(299) == 0);
            req = r_drv;
            for (int i = 0; i < 4; i++) done[i] = ($urandom_range(15) == 0);
            rst = rst_drv;
            @(posedge clk);
            #1;
            chk("rand.onehot0", 32'($onehot0(drv_en)), 32'h1);
            chk("rand.gnt_eq_drv", 32'(gnt), 32'(drv_en));
            chk("rand.pchg", 32'(bus_pchg), 32'(drv_en == 4'b0));
            if (drv_en != 4'b0) begin
                if (last_nz != 4'b0 && drv_en != last_nz)
                    chk("rand.dead_gap", 32'(zeros >= 1), 32'h1);
                last_nz = drv_en;
                zeros   = 0;
            end else begin
                zeros++;
            end
            for (int i = 0; i < 4; i++) begin
                if (rst_drv || !r_drv[i] || gnt[i]) wait_cnt[i] = 0;
                else wait_cnt[i]++;
                if (wait_cnt[i] > 27) begin
                    chk($sformatf("rand.starve%0d", i), 32'(wait_cnt[i]), 32'd27);
                    wait_cnt[i] = 0;
                end
            end
            rst = 1'b0;
        end
        $display("random run: %0d cycles", 10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
